pipe_tx_byte_scheduler: RTL and testbench

- Sequences MAC transmit words from the PIPE TX bus into a one-byte-per-cycle stream for the 8b/10b encoder.
- Handles 8/16/32-bit DataBusWidth, applies encoder backpressure, and arbitrates SKP ordered-set insertion against MAC data.
- Sits between the MAC-facing PIPE TX ports and the encoder/serializer in the PHY TX path.

---
 rtl/pipe_tx_byte_scheduler_pkg.sv | 24 ++
 rtl/pipe_tx_byte_scheduler_skp_timer.sv | 42 ++++
 rtl/pipe_tx_byte_scheduler.sv | 170 +++++++++++++++++
 tb/tb_pipe_tx_byte_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_tx_byte_scheduler_pkg.sv
// Shared types and constants for the PIPE TX byte scheduler: FSM encoding,
// SKP ordered-set symbols and the DataBusWidth decode.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_DATA = 2'd1,
        SEND_SKP  = 2'd2
    } tx_sched_state_e;

    localparam logic [7:0] K28_5_COM  = 8'hBC;
    localparam logic [7:0] K28_0_SKP  = 8'h1C;
    localparam int         SKP_OS_LEN = 4;

    // Unsupported widths fall back to a single byte per word.
    function automatic logic [2:0] width_to_nbytes(input logic [5:0] width);
        case (width)
            6'd16:   width_to_nbytes = 3'd2;
            6'd32:   width_to_nbytes = 3'd4;
            default: width_to_nbytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/pipe_tx_byte_scheduler_skp_timer.sv
// Counts consumed data bytes and raises pending once SKP_INTERVAL bytes have
// gone out since the last SKP ordered set.
module pipe_skp_timer #(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 12
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic byte_consumed_i,
    input  logic skp_start_i,
    output logic pending_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             at_limit;
    logic             near_limit;

    assign at_limit   = (count_q == CNT_W'(SKP_INTERVAL));
    assign near_limit = (count_q == CNT_W'(SKP_INTERVAL - 1));

    // Look ahead by the byte being consumed now, so a word whose last byte
    // reaches the interval is followed directly by the SKP, not one more word.
    assign pending_o = at_limit || (near_limit && byte_consumed_i);

    always_comb begin
        count_d = count_q;
        if (skp_start_i) begin
            count_d = '0;
        end else if (byte_consumed_i && !at_limit) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pipe_tx_byte_scheduler.sv
// PIPE TX byte scheduler: serialises 8/16/32-bit MAC words LSB first into a
// byte stream with encoder backpressure; SKP insertion under PIPE_TX_SKP_INSERT_EN.
module pipe_tx_byte_scheduler
    import pipe_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 12
) (
    input  logic        Ref_CLK,
    input  logic        Reset_n,
    input  logic [5:0]  DataBusWidth,
    input  logic [31:0] MAC_TX_Data,
    input  logic [3:0]  MAC_TX_DataK,
    input  logic        MAC_Data_En,
    output logic        Word_Ready,
    input  logic        Enc_Ready,
    output logic [7:0]  Enc_Data,
    output logic        Enc_DataK,
    output logic        Enc_Valid,
    output logic        Skp_Active
);

    tx_sched_state_e state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      last_idx_q, last_idx_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      k_q, k_d;

    logic            consume;
    logic            accept;
    logic            data_last;
    logic            skp_last;
    logic            skp_pending;
    logic            skp_done;
    logic [2:0]      nbytes;

    assign nbytes    = width_to_nbytes(DataBusWidth);
    assign Enc_Valid = (state_q != IDLE);
    assign consume   = Enc_Valid && Enc_Ready;
    assign data_last = (idx_q == last_idx_q);
    assign skp_last  = (idx_q == 2'(SKP_OS_LEN - 1));

`ifdef PIPE_TX_SKP_INSERT_EN
    logic skp_start;
    logic data_consumed;

    assign data_consumed = consume && (state_q == SEND_DATA);
    assign skp_start     = (state_d == SEND_SKP) && (state_q != SEND_SKP);
    assign skp_done      = consume && (state_q == SEND_SKP) && skp_last;
    assign Skp_Active    = (state_q == SEND_SKP);

    pipe_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL),
        .CNT_W       (CNT_W)
    ) u_skp_timer (
        .clk_i          (Ref_CLK),
        .rst_ni         (Reset_n),
        .byte_consumed_i(data_consumed),
        .skp_start_i    (skp_start),
        .pending_o      (skp_pending)
    );
`else
    logic unused_cfg;

    assign unused_cfg  = ^(SKP_INTERVAL + CNT_W) ^ skp_last;
    assign skp_done    = 1'b0;
    assign skp_pending = 1'b0;
    assign Skp_Active  = 1'b0;
`endif

    // Reset_n gates Word_Ready so every output reads 0 while reset is held.
    assign Word_Ready = Reset_n && !skp_pending &&
                        ((state_q == IDLE) ||
                         (consume && (state_q == SEND_DATA) && data_last) ||
                         skp_done);
    assign accept     = MAC_Data_En && Word_Ready;

    always_comb begin
        Enc_Data  = 8'h00;
        Enc_DataK = 1'b0;
        case (state_q)
            SEND_DATA: begin
                Enc_Data  = data_q[{idx_q, 3'b000} +: 8];
                Enc_DataK = k_q[idx_q];
            end
`ifdef PIPE_TX_SKP_INSERT_EN
            SEND_SKP: begin
                Enc_Data  = (idx_q == 2'd0) ? K28_5_COM : K28_0_SKP;
                Enc_DataK = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        data_d     = data_q;
        k_d        = k_q;

        if (accept) begin
            data_d     = MAC_TX_Data;
            k_d        = MAC_TX_DataK;
            last_idx_d = 2'(nbytes - 3'd1);
            idx_d      = 2'd0;
        end

        case (state_q)
            IDLE: begin
                if (skp_pending) begin
                    state_d = SEND_SKP;
                    idx_d   = 2'd0;
                end else if (accept) begin
                    state_d = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (consume) begin
                    if (data_last) begin
                        idx_d = 2'd0;
                        if (skp_pending) begin
                            state_d = SEND_SKP;
                        end else if (accept) begin
                            state_d = SEND_DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
`ifdef PIPE_TX_SKP_INSERT_EN
            SEND_SKP: begin
                if (consume) begin
                    if (skp_last) begin
                        idx_d   = 2'd0;
                        state_d = accept ? SEND_DATA : IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Ref_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            last_idx_q <= 2'd0;
            data_q     <= 32'h0;
            k_q        <= 4'h0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            data_q     <= data_d;
            k_q        <= k_d;
        end
    end

endmodule

// File: tb/tb_pipe_tx_byte_scheduler.sv
// Scoreboard bench for pipe_tx_byte_scheduler: drivers push the expected byte
// stream into exp_q, and a negedge monitor compares every byte on the encoder side.
module tb_pipe_tx_byte_scheduler;

    localparam int SKP_N = 8;

    logic        Ref_CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic [5:0]  DataBusWidth = 6'd32;
    logic [31:0] MAC_TX_Data = 32'h0;
    logic [3:0]  MAC_TX_DataK = 4'h0;
    logic        MAC_Data_En = 1'b0;
    logic        Word_Ready;
    logic        Enc_Ready = 1'b1;
    logic [7:0]  Enc_Data;
    logic        Enc_DataK;
    logic        Enc_Valid;
    logic        Skp_Active;

    // Entry layout: {skp_active, k, data}
    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int model_cnt = 0;

    pipe_tx_byte_scheduler #(
        .SKP_INTERVAL(SKP_N),
        .CNT_W       (12)
    ) dut (
        .Ref_CLK     (Ref_CLK),
        .Reset_n     (Reset_n),
        .DataBusWidth(DataBusWidth),
        .MAC_TX_Data (MAC_TX_Data),
        .MAC_TX_DataK(MAC_TX_DataK),
        .MAC_Data_En (MAC_Data_En),
        .Word_Ready  (Word_Ready),
        .Enc_Ready   (Enc_Ready),
        .Enc_Data    (Enc_Data),
        .Enc_DataK   (Enc_DataK),
        .Enc_Valid   (Enc_Valid),
        .Skp_Active  (Skp_Active)
    );

    // ---------------- clock / watchdog ----------------
    always #5 Ref_CLK = ~Ref_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [5:0] w, input logic [31:0] d, input logic [3:0] k);
        int nb;
        nb = (w == 6'd32) ? 4 : (w == 6'd16) ? 2 : 1;
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back({1'b0, k[i], d[8*i +: 8]});
        end
`ifdef PIPE_TX_SKP_INSERT_EN
        model_cnt += nb;
        if (model_cnt >= SKP_N) begin
            exp_q.push_back({1'b1, 1'b1, 8'hBC});
            for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 1'b1, 8'h1C});
            model_cnt = 0;
        end
`endif
    endtask

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send_word(input logic [5:0] w, input logic [31:0] d, input logic [3:0] k);
        bit got;
        got          = 1'b0;
        DataBusWidth = w;
        MAC_TX_Data  = d;
        MAC_TX_DataK = k;
        MAC_Data_En  = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge Ref_CLK);
            if (Word_Ready) begin
                push_word(w, d, k);
                got = 1'b1;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL word_accept: got no Word_Ready expected accept of %h", d);
        end
        @(posedge Ref_CLK);
        #1;
        MAC_Data_En = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n   = 1'b0;
        Enc_Ready = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge Ref_CLK);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge Ref_CLK);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL drain: got %0d bytes outstanding expected 0", exp_q.size());
        end
        repeat (2) @(negedge Ref_CLK);
        check("idle_after_drain", {31'h0, Enc_Valid}, 32'h0);
        @(posedge Ref_CLK);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge Ref_CLK) begin
        if (Reset_n) begin
            if (Enc_Valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got %h expected none", {Skp_Active, Enc_DataK, Enc_Data});
                end else begin
                    check("enc_byte", {22'h0, Skp_Active, Enc_DataK, Enc_Data}, {22'h0, exp_q[0]});
                    if (Enc_Ready) void'(exp_q.pop_front());
                end
            end else begin
                check("skp_idle", {31'h0, Skp_Active}, 32'h0);
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        #1;
        check("rst_valid", {31'h0, Enc_Valid},  32'h0);
        check("rst_data",  {24'h0, Enc_Data},   32'h0);
        check("rst_ready", {31'h0, Word_Ready}, 32'h0);
        do_reset();

        // Back-to-back 32-bit words: Word_Ready only on the 4th byte, no bubble.
        DataBusWidth = 6'd32;
        MAC_TX_Data  = 32'h44332211;
        MAC_TX_DataK = 4'b0001;
        MAC_Data_En  = 1'b1;
        @(negedge Ref_CLK);
        check("wr_idle", {31'h0, Word_Ready}, 32'h1);
        push_word(6'd32, 32'h44332211, 4'b0001);
        @(posedge Ref_CLK);
        #1;
        MAC_TX_Data  = 32'h88776655;
        MAC_TX_DataK = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge Ref_CLK);
            check("wr_word_end", {31'h0, Word_Ready}, (k == 3) ? 32'h1 : 32'h0);
            if (k == 3) push_word(6'd32, 32'h88776655, 4'b0000);
        end
        @(posedge Ref_CLK);
        #1;
        MAC_Data_En = 1'b0;
        @(negedge Ref_CLK);
        check("no_bubble", {31'h0, Enc_Valid}, 32'h1);
        drain();

        // 16-bit word with a 3-cycle encoder stall on the first byte.
        do_reset();
        send_word(6'd16, 32'h0000BEEF, 4'b0000);
        Enc_Ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Ref_CLK);
            check("stall_valid", {31'h0, Enc_Valid},  32'h1);
            check("stall_wr",    {31'h0, Word_Ready}, 32'h0);
        end
        @(posedge Ref_CLK);
        #1;
        Enc_Ready = 1'b1;
        @(negedge Ref_CLK);
        check("wr_first_of_two", {31'h0, Word_Ready}, 32'h0);
        drain();

        // Continuous 32-bit words; SKP after every 8 data bytes when enabled.
        do_reset();
        send_word(6'd32, 32'h03020100, 4'b0000);
        send_word(6'd32, 32'h07060504, 4'b0010);
        send_word(6'd32, 32'h0B0A0908, 4'b0000);
        send_word(6'd32, 32'h0F0E0D0C, 4'b1000);
        send_word(6'd32, 32'h13121110, 4'b0000);
        drain();

        // Width change mid-word only affects the next word.
        do_reset();
        send_word(6'd32, 32'hDDCCBBAA, 4'b1000);
        DataBusWidth = 6'd8;
        send_word(6'd8,  32'h000000F0, 4'b0000);
        send_word(6'd24, 32'h12345677, 4'b0001);
        drain();

        // Asynchronous reset after byte 1 of a 4-byte word.
        do_reset();
        send_word(6'd32, 32'hA3A2A1A0, 4'b0000);
        repeat (2) @(negedge Ref_CLK);
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, Enc_Valid},  32'h0);
        check("arst_data",  {24'h0, Enc_Data},   32'h0);
        check("arst_k",     {31'h0, Enc_DataK},  32'h0);
        check("arst_skp",   {31'h0, Skp_Active}, 32'h0);
        check("arst_wr",    {31'h0, Word_Ready}, 32'h0);
        exp_q.delete();
        model_cnt = 0;
        @(posedge Ref_CLK);
        #1;
        Reset_n = 1'b1;
        @(negedge Ref_CLK);
        check("wr_after_rst", {31'h0, Word_Ready}, 32'h1);
        @(posedge Ref_CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            send_word(6'd16, {16'h0, 8'(8'h50 + 2*i + 1), 8'(8'h50 + 2*i)}, 4'b0000);
        end
        drain();

        // Twenty words of mixed width.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send_word((i % 3 == 0) ? 6'd8 : (i % 3 == 1) ? 6'd16 : 6'd32,
                      32'hC0DE0000 + 32'(i * 32'h0101), 4'(i));
        end
        drain();

        check("queue_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
